// File: rtl/unspinner_pkg.sv
// rtl/unspinner_pkg.sv - shared constants and types for the unspinner word de-rotator
package unspinner_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_e;

    typedef logic [2:0] stage_t;

    localparam stage_t LAST_STAGE = 3'd4;

endpackage

// File: rtl/unspinner_if.sv
// rtl/unspinner_if.sv - command/status bundle between the unspinner and its driver
interface unspinner_if;
    import unspinner_pkg::*;

    logic             load;
    logic [WIDTH-1:0] din;
    logic             spin;
    logic [SHW-1:0]   amount;
    logic             restore;
    logic [WIDTH-1:0] dout;
    logic [SHW-1:0]   offset;
    logic             busy;
    logic             done;
    logic             restore_err;

    modport master (
        output load, din, spin, amount, restore,
        input  dout, offset, busy, done, restore_err
    );

    modport slave (
        input  load, din, spin, amount, restore,
        output dout, offset, busy, done, restore_err
    );

endinterface

// File: rtl/unspinner_rotl32.sv
// rtl/unspinner_rotl32.sv - combinational logarithmic left rotator used by the spin command
module rotl32
    import unspinner_pkg::*;
(
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   amount_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stg [SHW+1];

    assign stg[0] = data_i;

    // Stage i rotates by 2^i when amount bit i is set.
    for (genvar i = 0; i < SHW; i++) begin : g_stage
        localparam int S = 1 << i;
        assign stg[i+1] = amount_i[i] ? {stg[i][WIDTH-1-S:0], stg[i][WIDTH-1 -: S]} : stg[i];
    end

    assign data_o = stg[SHW];

endmodule

// File: rtl/unspinner.sv
// rtl/unspinner.sv - word register with left-rotate commands and a fixed 5-cycle restore
// Optional macro UNSPINNER_CHECK_EN adds a load shadow and a sticky restore mismatch flag.
module unspinner
    import unspinner_pkg::*;
(
    input  logic         clock_i,
    input  logic         reset_i,
    unspinner_if.slave   bus
);

    state_e           state_q, state_d;
    stage_t           stage_q, stage_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SHW-1:0]   offset_q, offset_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] spun;
    logic [WIDTH-1:0] rotr;
    logic             stage_bit;

    rotl32 u_rotl32 (
        .data_i   (dout_q),
        .amount_i (bus.amount),
        .data_o   (spun)
    );

    // One right-rotate by 2^stage; the offset bit for that stage decides whether it applies.
    always_comb begin
        rotr      = dout_q;
        stage_bit = 1'b0;
        case (stage_q)
            3'd0:    begin rotr = {dout_q[0],    dout_q[31:1]};  stage_bit = offset_q[0]; end
            3'd1:    begin rotr = {dout_q[1:0],  dout_q[31:2]};  stage_bit = offset_q[1]; end
            3'd2:    begin rotr = {dout_q[3:0],  dout_q[31:4]};  stage_bit = offset_q[2]; end
            3'd3:    begin rotr = {dout_q[7:0],  dout_q[31:8]};  stage_bit = offset_q[3]; end
            default: begin rotr = {dout_q[15:0], dout_q[31:16]}; stage_bit = offset_q[4]; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        dout_d   = dout_q;
        offset_d = offset_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    dout_d   = bus.din;
                    offset_d = '0;
                end else if (bus.restore) begin
                    state_d = RESTORE;
                    stage_d = '0;
                end else if (bus.spin) begin
                    dout_d   = spun;
                    offset_d = offset_q + bus.amount;
                end
            end
            RESTORE: begin
                if (stage_bit) begin
                    dout_d             = rotr;
                    offset_d[stage_q]  = 1'b0;
                end
                if (stage_q == LAST_STAGE) begin
                    state_d = IDLE;
                    stage_d = '0;
                    done_d  = 1'b1;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            dout_q   <= '0;
            offset_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            dout_q   <= dout_d;
            offset_q <= offset_d;
            done_q   <= done_d;
        end
    end

`ifdef UNSPINNER_CHECK_EN
    logic [WIDTH-1:0] shadow_q;
    logic             err_q;

    // Compare the value leaving the last stage, so the flag lines up with done.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else if (state_q == IDLE && bus.load) begin
            shadow_q <= bus.din;
            err_q    <= 1'b0;
        end else if (done_d && (dout_d != shadow_q)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.restore_err = err_q;
`else
    assign bus.restore_err = 1'b0;
`endif

    assign bus.dout   = dout_q;
    assign bus.offset = offset_q;
    assign bus.busy   = (state_q == RESTORE);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_unspinner.sv
// tb/tb_unspinner.sv - directed self-checking bench for unspinner
module tb_unspinner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    unspinner_if bus ();

    unspinner dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input logic [31:0] d, input logic [4:0] o,
                          input logic b, input logic dn);
        chk({tag, " dout"},   bus.dout,          d);
        chk({tag, " offset"}, {27'd0, bus.offset}, {27'd0, o});
        chk({tag, " busy"},   {31'd0, bus.busy},   {31'd0, b});
        chk({tag, " done"},   {31'd0, bus.done},   {31'd0, dn});
        chk({tag, " err"},    {31'd0, bus.restore_err}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load = 1'b0; bus.spin = 1'b0; bus.restore = 1'b0;
        bus.din = '0; bus.amount = '0;
    endtask

    task automatic do_load(input logic [31:0] w);
        bus.load = 1'b1; bus.din = w;
        tick();
        idle_inputs();
    endtask

    task automatic do_spin(input logic [4:0] a);
        bus.spin = 1'b1; bus.amount = a;
        tick();
        idle_inputs();
    endtask

    task automatic do_restore();
        bus.restore = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #2;
        status("reset", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        do_load(32'h80000001);
        status("load1", 32'h80000001, 5'd0, 1'b0, 1'b0);
        do_spin(5'd1);
        status("spin1", 32'h00000003, 5'd1, 1'b0, 1'b0);

        do_load(32'h12345678);
        do_spin(5'd4);
        status("spin4", 32'h23456781, 5'd4, 1'b0, 1'b0);
        do_spin(5'd8);
        status("spin8", 32'h45678123, 5'd12, 1'b0, 1'b0);

        // restore sampled at edge N; stage 2 and 3 rotate right 4 and 8
        do_restore();
        status("rst_N", 32'h45678123, 5'd12, 1'b1, 1'b0);
        bus.spin = 1'b1; bus.amount = 5'd7;
        tick();
        status("rst_N1_spin_ign", 32'h45678123, 5'd12, 1'b1, 1'b0);
        bus.load = 1'b1; bus.din = 32'hFFFFFFFF;
        tick();
        status("rst_N2_load_ign", 32'h45678123, 5'd12, 1'b1, 1'b0);
        idle_inputs();
        tick();
        status("rst_N3", 32'h34567812, 5'd8, 1'b1, 1'b0);
        tick();
        status("rst_N4", 32'h12345678, 5'd0, 1'b1, 1'b0);
        tick();
        status("rst_N5_done", 32'h12345678, 5'd0, 1'b0, 1'b1);
        tick();
        status("rst_N6", 32'h12345678, 5'd0, 1'b0, 1'b0);

        do_load(32'hDEADBEEF);
        do_spin(5'd31);
        status("spin31", 32'hEF56DF77, 5'd31, 1'b0, 1'b0);
        do_spin(5'd1);
        status("wrap", 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
        do_restore();
        for (int i = 0; i < 5; i++) begin
            status("wrap_busy", 32'hDEADBEEF, 5'd0, 1'b1, 1'b0);
            tick();
        end
        status("wrap_done", 32'hDEADBEEF, 5'd0, 1'b0, 1'b1);
        // command in the done cycle is accepted
        bus.spin = 1'b1; bus.amount = 5'd16;
        tick();
        idle_inputs();
        status("done_cycle_spin", 32'hBEEFDEAD, 5'd16, 1'b0, 1'b0);

        bus.load = 1'b1; bus.din = 32'h0000000F; bus.spin = 1'b1; bus.amount = 5'd3;
        tick();
        idle_inputs();
        status("load_wins", 32'h0000000F, 5'd0, 1'b0, 1'b0);

        do_spin(5'd5);
        status("spin5", 32'h000001E0, 5'd5, 1'b0, 1'b0);
        do_restore();
        tick();
        status("abort_N1", 32'h000000F0, 5'd4, 1'b1, 1'b0);
        tick();
        #3;
        rst = 1'b1;
        #1;
        status("abort_async", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        status("abort_held", 32'h0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", {31'd0, bus.done}, 32'd0);
        end
        do_load(32'hA5A5A5A5);
        status("post_reset_load", 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
